// File: rtl/tx_arbiter.sv
// tx_arbiter
// Two-requester round-robin arbiter in front of a shared UART transmitter.
// The winner's payload is latched and offered to the transmitter with
// req_tx; the requester is acknowledged once the transmitter finishes or
// the wait times out.
//
// Handshakes (all four-phase, level based):
//   requester side : reqN rises -> ackN rises when its transfer is done;
//                    reqN falls -> ackN falls one cycle later.
//   transmitter    : req_tx rises -> ack_tx rises when sent; req_tx falls ->
//                    ack_tx is released by the transmitter afterwards.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req0/req1         : level requests
//   dout0/dout1       : payloads, type0/type1 : payload types
//   ack0/ack1         : acknowledges to requesters
//   req_tx, dout_tx, type_tx : request + payload to transmitter
//   ack_tx            : transmitter done
//   owner             : index of granted requester
//   busy              : high whenever the FSM is not IDLE
//   tmo               : one-cycle pulse on a timeout abort
//   fsm_state         : current FSM state (debug)
module tx_arbiter #(
    parameter int          DATAWIDTH = 32,
    parameter logic [15:0] TIMEOUT   = 16'd60000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [DATAWIDTH-1:0] dout0,
    input  logic [DATAWIDTH-1:0] dout1,
    input  logic                 type0,
    input  logic                 type1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 req_tx,
    output logic [DATAWIDTH-1:0] dout_tx,
    output logic                 type_tx,
    input  logic                 ack_tx,
    output logic                 owner,
    output logic                 busy,
    output logic                 tmo,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [15:0]          cnt, cnt_nxt;
    logic                 ptr, ptr_nxt;      // last requester served
    logic                 ack0_nxt, ack1_nxt, req_tx_nxt, type_tx_nxt;
    logic                 owner_nxt, busy_nxt, tmo_nxt;
    logic [DATAWIDTH-1:0] dout_tx_nxt;
    logic                 winner;
    logic                 owner_req;

    assign fsm_state = state;

    // On a tie the requester that was not served last wins.
    assign winner    = (req0 && req1) ? ~ptr : req1;
    assign owner_req = owner ? req1 : req0;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ptr_nxt     = ptr;
        ack0_nxt    = ack0;
        ack1_nxt    = ack1;
        req_tx_nxt  = req_tx;
        dout_tx_nxt = dout_tx;
        type_tx_nxt = type_tx;
        owner_nxt   = owner;
        busy_nxt    = busy;
        tmo_nxt     = 1'b0;
        case (state)
            IDLE: begin
                // Never start while the transmitter still reports the
                // previous transfer as done.
                if (!ack_tx && (req0 || req1)) begin
                    state_nxt   = WAIT;
                    owner_nxt   = winner;
                    dout_tx_nxt = winner ? dout1 : dout0;
                    type_tx_nxt = winner ? type1 : type0;
                    req_tx_nxt  = 1'b1;
                    busy_nxt    = 1'b1;
                    cnt_nxt     = 16'd0;
                end
            end
            WAIT: begin
                // ack_tx takes priority over the timeout on the same cycle.
                if (ack_tx || (cnt == TIMEOUT - 16'd1)) begin
                    state_nxt  = DONE;
                    req_tx_nxt = 1'b0;
                    tmo_nxt    = ~ack_tx;
                    ptr_nxt    = owner;
                    ack0_nxt   = ~owner;
                    ack1_nxt   = owner;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DONE: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                    ack0_nxt  = 1'b0;
                    ack1_nxt  = 1'b0;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                req_tx_nxt = 1'b0;
                ack0_nxt   = 1'b0;
                ack1_nxt   = 1'b0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            ptr     <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            req_tx  <= 1'b0;
            dout_tx <= '0;
            type_tx <= 1'b0;
            owner   <= 1'b0;
            busy    <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ptr     <= ptr_nxt;
            ack0    <= ack0_nxt;
            ack1    <= ack1_nxt;
            req_tx  <= req_tx_nxt;
            dout_tx <= dout_tx_nxt;
            type_tx <= type_tx_nxt;
            owner   <= owner_nxt;
            busy    <= busy_nxt;
            tmo     <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed stimulus; grants and completions are
// queued as expectations and checked by a monitor on the falling edge.
module tb_tx_arbiter;

    localparam int DW = 32;
    localparam int W  = DW + 2;            // {owner, type, data}
    localparam int S_REQ_TX = 0;
    localparam int S_ACK0   = 1;
    localparam int S_ACK1   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [DW-1:0] dout0 = '0, dout1 = '0;
    logic          type0 = 1'b0, type1 = 1'b0;
    logic          ack0, ack1, req_tx, type_tx, owner, busy, tmo;
    logic [DW-1:0] dout_tx;
    logic          ack_tx = 1'b0;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];                // expected grants
    logic [2:0]   done_q[$];               // expected {tmo, ack1, ack0} at completion

    tx_arbiter #(.DATAWIDTH(DW), .TIMEOUT(16'd16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .dout0(dout0), .dout1(dout1),
        .type0(type0), .type1(type1),
        .ack0(ack0), .ack1(ack1),
        .req_tx(req_tx), .dout_tx(dout_tx), .type_tx(type_tx),
        .ack_tx(ack_tx),
        .owner(owner), .busy(busy), .tmo(tmo),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic req_tx_prev = 1'b0, ack0_prev = 1'b0, ack1_prev = 1'b0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [2:0]   d;
        if (req_tx && !req_tx_prev) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL grant_unexpected actual=%0h required=none", {owner, type_tx, dout_tx});
            end else begin
                e = exp_q.pop_front();
                chk("grant", {30'd0, owner, type_tx, dout_tx}, {30'd0, e});
            end
        end
        if ((ack0 && !ack0_prev) || (ack1 && !ack1_prev)) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ack_unexpected actual=%0b required=none", {tmo, ack1, ack0});
            end else begin
                d = done_q.pop_front();
                chk("done", {61'd0, tmo, ack1, ack0}, {61'd0, d});
            end
        end
        req_tx_prev = req_tx;
        ack0_prev   = ack0;
        ack1_prev   = ack1;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_for(input int sel, input logic val, input string name);
        logic cur;
        bit   hit;
        hit = 0;
        cur = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cur = (sel == S_REQ_TX) ? req_tx : ((sel == S_ACK0) ? ack0 : ack1);
            if (cur == val) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=%0b required=%0b", name, cur, val);
        end
    endtask

    // Transmitter model: answer the next request after a short delay.
    task automatic do_ack();
        wait_for(S_REQ_TX, 1'b1, "req_tx_rise");
        repeat (2) @(negedge clk);
        ack_tx = 1'b1;
        wait_for(S_REQ_TX, 1'b0, "req_tx_fall");
        ack_tx = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; ack_tx = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_tx", req_tx, 0);
        chk("rst_acks", {ack1, ack0}, 0);
        chk("rst_busy_tmo", {busy, tmo}, 0);
        chk("rst_dout_tx", dout_tx, 0);
        chk("rst_type_owner", {type_tx, owner}, 0);
        chk("rst_state", fsm_state, 0);
        rst = 1'b0;

        // Single request from requester 0
        @(negedge clk);
        req0 = 1'b1; dout0 = 32'h12345678; type0 = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 32'h12345678});
        @(posedge clk); #1;
        chk("single_req_tx", req_tx, 1);
        chk("single_owner", owner, 0);
        chk("single_dout", dout_tx, 32'h12345678);
        chk("single_busy", busy, 1);
        @(negedge clk);
        dout0 = 32'hdeadbeef; type0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_stable_dout", dout_tx, 32'h12345678);
        chk("wait_stable_type", {type_tx, req_tx}, 2'b11);
        ack_tx = 1'b1;
        done_q.push_back(3'b001);
        @(posedge clk); #1;
        chk("done_req_tx_low", req_tx, 0);
        chk("done_acks", {tmo, ack1, ack0}, 3'b001);
        @(negedge clk);
        ack_tx = 1'b0;
        repeat (3) @(negedge clk);
        chk("ack0_held", ack0, 1);
        req0 = 1'b0;
        @(posedge clk); #1;
        chk("ack0_release", {busy, ack0}, 0);
        chk("idle_hold_dout", dout_tx, 32'h12345678);

        // Simultaneous requests after reset; round-robin order 0,1,0,1
        do_reset();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        dout0 = 32'haaaa0001; type0 = 1'b0;
        dout1 = 32'hbbbb0002; type1 = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'haaaa0001});
        exp_q.push_back({1'b1, 1'b1, 32'hbbbb0002});
        done_q.push_back(3'b001);
        done_q.push_back(3'b010);
        do_ack();
        wait_for(S_ACK0, 1'b1, "ack0_rise");
        chk("pending_unacked", ack1, 0);
        req0 = 1'b0;
        wait_for(S_ACK0, 1'b0, "ack0_fall");
        do_ack();
        wait_for(S_ACK1, 1'b1, "ack1_rise");
        chk("other_ack_low", ack0, 0);
        dout0 = 32'hcccc0003; req0 = 1'b1; req1 = 1'b0;
        wait_for(S_ACK1, 1'b0, "ack1_fall");
        req1 = 1'b1;                       // tie with req0 on the next edge
        exp_q.push_back({1'b0, 1'b0, 32'hcccc0003});
        exp_q.push_back({1'b1, 1'b1, 32'hbbbb0002});
        done_q.push_back(3'b001);
        done_q.push_back(3'b010);
        do_ack();
        wait_for(S_ACK0, 1'b1, "ack0_rise");
        req0 = 1'b0;
        wait_for(S_ACK0, 1'b0, "ack0_fall");
        do_ack();
        wait_for(S_ACK1, 1'b1, "ack1_rise");
        req1 = 1'b0;
        wait_for(S_ACK1, 1'b0, "ack1_fall");

        // Timeout abort: req_tx held for 16 WAIT cycles
        @(negedge clk);
        req0 = 1'b1; dout0 = 32'h00007e57; type0 = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'h00007e57});
        done_q.push_back(3'b101);
        wait_for(S_REQ_TX, 1'b1, "req_tx_rise");
        repeat (15) @(negedge clk);
        chk("tmo_before", {tmo, req_tx}, 2'b01);
        @(negedge clk);
        chk("tmo_pulse", {tmo, req_tx, ack0}, 3'b101);
        @(negedge clk);
        chk("tmo_one_cycle", {tmo, ack0}, 2'b01);
        req0 = 1'b0;
        wait_for(S_ACK0, 1'b0, "ack0_fall");

        // ack_tx on the same cycle the counter reaches its limit
        @(negedge clk);
        req1 = 1'b1; dout1 = 32'h5a5a0005; type1 = 1'b1;
        exp_q.push_back({1'b1, 1'b1, 32'h5a5a0005});
        done_q.push_back(3'b010);
        wait_for(S_REQ_TX, 1'b1, "req_tx_rise");
        repeat (15) @(negedge clk);
        ack_tx = 1'b1;
        @(negedge clk);
        chk("ack_wins_tmo", {tmo, req_tx, ack1}, 3'b001);
        ack_tx = 1'b0; req1 = 1'b0;
        wait_for(S_ACK1, 1'b0, "ack1_fall");

        // ack_tx stuck high in IDLE blocks arbitration
        @(negedge clk);
        ack_tx = 1'b1; req1 = 1'b1; dout1 = 32'h0bad0006; type1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stuck_ack_no_grant", {busy, req_tx}, 2'b00);
        end
        ack_tx = 1'b0;
        exp_q.push_back({1'b1, 1'b1, 32'h0bad0006});
        wait_for(S_REQ_TX, 1'b1, "req_tx_rise");

        // Reset in the middle of WAIT
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req_tx", req_tx, 0);
        chk("async_rst_flags", {busy, tmo, ack1, ack0}, 0);
        chk("async_rst_data", {owner, type_tx, dout_tx}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({1'b1, 1'b1, 32'h0bad0006});
        done_q.push_back(3'b010);
        do_ack();
        wait_for(S_ACK1, 1'b1, "ack1_rise");
        req1 = 1'b0;
        wait_for(S_ACK1, 1'b0, "ack1_fall");

        repeat (3) @(negedge clk);
        chk("grants_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 The module SHALL have parameter DATAWIDTH, default 32, setting the payload width.
REQ-002 The module SHALL have parameter TIMEOUT, default 16'd60000, setting the max WAIT cycles before abort.
REQ-003 The module SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 The module SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 The module SHALL have ports req0/req1  in  1  level request from requester 0/1.
REQ-006 The module SHALL have ports dout0/dout1  in  DATAWIDTH  payload of requester 0/1.
REQ-007 The module SHALL have ports type0/type1  in  1  payload type (char/data) of requester 0/1.
REQ-008 The module SHALL have ports ack0/ack1  out  1  four-phase acknowledge to requester 0/1.
REQ-009 The module SHALL have port req_tx  out  1  request to the shared UART transmitter.
REQ-010 The module SHALL have port dout_tx  out  DATAWIDTH  payload to transmitter.
REQ-011 The module SHALL have port type_tx  out  1  payload type to transmitter.
REQ-012 The module SHALL have port ack_tx  in  1  transmitter done (held high until req_tx drops).
REQ-013 The module SHALL have port owner  out  1  index of the requester currently granted.
REQ-014 The module SHALL have port busy  out  1  high in any state except IDLE.
REQ-015 The module SHALL have port tmo  out  1  one-cycle pulse on timeout abort.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, DONE; all outputs registered.
REQ-017 IDLE: arbitration SHALL occur only when ack_tx==0 and (req0|req1); otherwise stay IDLE.
REQ-018 Arbitration SHALL be round-robin: single request wins outright; on a tie, the requester not served last wins.
REQ-019 On a grant at edge N, owner, dout_tx, type_tx SHALL be latched from the winner and req_tx SHALL be 1 from cycle N+1 (1-cycle latency), entering WAIT.
REQ-020 WAIT: req_tx, dout_tx, type_tx, owner SHALL remain stable regardless of requester inputs.
REQ-021 WAIT: a 16-bit counter SHALL count from 0; on ack_tx==1, the FSM SHALL go to DONE with req_tx=0 next cycle.
REQ-022 WAIT: if the counter reaches TIMEOUT-1 with ack_tx==0, the FSM SHALL go to DONE, req_tx=0, and tmo SHALL pulse for exactly one cycle.
REQ-023 If ack_tx==1 in the same cycle the counter reaches TIMEOUT-1, ack SHALL win and tmo SHALL stay 0.
REQ-024 DONE: ack[owner] SHALL be 1 and the other ack SHALL be 0; the FSM SHALL stay in DONE until req[owner]==0, then go to IDLE with ack[owner]=0 next cycle.
REQ-025 The round-robin pointer SHALL update to owner on entry to DONE (normal or timeout).
REQ-026 A requester dropping req while in WAIT SHALL NOT abort the transfer; latched data completes.
REQ-027 The non-owner's request SHALL be held pending, unacknowledged, until the next IDLE arbitration.
REQ-028 dout_tx and type_tx SHALL hold their last value in IDLE and DONE.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, req_tx=0, ack0=ack1=0, busy=0, tmo=0, dout_tx=0, type_tx=0, owner=0, counter=0, pointer=1 (requester 0 wins the first tie).
REQ-030 Reset asserted mid-WAIT SHALL drop req_tx immediately; after release, the FSM SHALL re-arbitrate from IDLE with no ack issued for the aborted transfer.

Verification
REQ-031 req0=1, dout0=32'h12345678, type0=1, req1=0 -> req_tx=1 next cycle, dout_tx=32'h12345678, owner=0; ack_tx pulse high -> ack0=1 until req0 drops.
REQ-032 req0 and req1 rise in the same cycle after reset -> requester 0 served first, then requester 1 with no intervening idle request lost; the third tie goes to 0.
REQ-033 TIMEOUT=16, ack_tx held 0 -> tmo pulses once at WAIT cycle 16, req_tx falls, and ack0 is asserted.
REQ-034 ack_tx=1 on the exact cycle the counter hits TIMEOUT-1 -> tmo=0 and a normal DONE occurs.
REQ-035 With ack_tx stuck at 1 in IDLE and req1=1 -> no grant until ack_tx=0, then grant to requester 1.
REQ-036 rst pulsed during WAIT -> all outputs 0 asynchronously; after release, with req1 still high -> fresh grant to requester 1.
